// File: rtl/apu_frame_counter.sv
// rtl/apu_frame_counter.sv - APU frame sequencer: $4017 mode/inhibit, $4015 frame IRQ, quarter/half-frame pulses
// Optional macro APU_FRAME_PAL_EN selects PAL step counts instead of NTSC.
module apu_frame_counter #(
   parameter logic [15:0] ADDR_CTRL = 16'h4017,
   parameter logic [15:0] ADDR_STAT = 16'h4015
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic [15:0] addr,
   input  logic        rw,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        irq_n,
   output logic        qframe,
   output logic        hframe
);

`ifdef APU_FRAME_PAL_EN
   localparam logic [15:0] STEP1    = 16'd8313;
   localparam logic [15:0] STEP2    = 16'd16627;
   localparam logic [15:0] STEP3    = 16'd24939;
   localparam logic [15:0] STEP4_M0 = 16'd33252;
   localparam logic [15:0] STEP4_M1 = 16'd41565;
`else
   localparam logic [15:0] STEP1    = 16'd7457;
   localparam logic [15:0] STEP2    = 16'd14913;
   localparam logic [15:0] STEP3    = 16'd22371;
   localparam logic [15:0] STEP4_M0 = 16'd29828;
   localparam logic [15:0] STEP4_M1 = 16'd37281;
`endif
   localparam logic [15:0] LAST_M0 = STEP4_M0 + 16'd1;

   logic [15:0] cnt;
   logic        mode;
   logic        inhibit;
   logic        flag;

   logic        ctrl_wr;
   logic        stat_rd;
   logic        step_q;
   logic        step_h;
   logic        set_ev;
   logic        wrap;
   logic        flag_next;

   assign ctrl_wr  = cpu_en && !rw && (addr == ADDR_CTRL);
   assign stat_rd  = cpu_en && rw && (addr == ADDR_STAT);
   assign data_oe  = rw && (addr == ADDR_STAT);
   assign data_out = {1'b0, data_oe & flag, 6'b000000};

   always_comb begin
      step_h = (cnt == STEP2) || (cnt == (mode ? STEP4_M1 : STEP4_M0));
      step_q = step_h || (cnt == STEP1) || (cnt == STEP3);
      set_ev = !mode && !inhibit && ((cnt == STEP4_M0) || (cnt == LAST_M0));
      wrap   = mode ? (cnt == STEP4_M1) : (cnt == LAST_M0);
   end

   // A coinciding set beats the read-clear; a CTRL write beats everything.
   always_comb begin
      flag_next = flag;
      if (cpu_en) begin
         if (ctrl_wr) begin
            if (data_in[6])
               flag_next = 1'b0;
         end else if (set_ev) begin
            flag_next = 1'b1;
         end else if (stat_rd) begin
            flag_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= 16'd0;
         mode    <= 1'b0;
         inhibit <= 1'b0;
         flag    <= 1'b0;
         irq_n   <= 1'b1;
         qframe  <= 1'b0;
         hframe  <= 1'b0;
      end else begin
         qframe <= 1'b0;
         hframe <= 1'b0;
         flag   <= flag_next;
         irq_n  <= ~flag_next;
         if (cpu_en) begin
            if (ctrl_wr) begin
               mode    <= data_in[7];
               inhibit <= data_in[6];
               cnt     <= 16'd0;
               qframe  <= data_in[7];
               hframe  <= data_in[7];
            end else begin
               cnt    <= wrap ? 16'd0 : cnt + 16'd1;
               qframe <= step_q;
               hframe <= step_h;
            end
         end
      end
   end

endmodule
